// File: rtl/i2c_bus_cond_det.sv
// Multi-channel I2C bus-condition detector: synchronises and glitch-filters SCL/SDA,
// then reports START / repeated START / STOP, bus-busy, SCL-low timeout and arbitration loss.

module i2c_line_filter #(
    parameter int FILT_LEN = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic line_in,
    output logic line_f
);

    localparam int CW = $clog2(FILT_LEN + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILT_LEN - 1);

    logic          s1;
    logic          s2;
    logic [CW-1:0] cnt;

    // The filtered level only moves after s2 has disagreed with it for FILT_LEN clocks in a row.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1     <= 1'b1;
            s2     <= 1'b1;
            cnt    <= '0;
            line_f <= 1'b1;
        end else begin
            s1 <= line_in;
            s2 <= s1;
            if (s2 == line_f) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                line_f <= s2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

module i2c_bus_cond_det #(
    parameter int NUM_CH   = 1,
    parameter int FILT_LEN = 3,
    parameter int TIMEOUT  = 1000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] scl_in,
    input  logic [NUM_CH-1:0] sda_in,
    input  logic [NUM_CH-1:0] sda_drive,
    output logic [NUM_CH-1:0] scl_f,
    output logic [NUM_CH-1:0] sda_f,
    output logic [NUM_CH-1:0] start_p,
    output logic [NUM_CH-1:0] rstart_p,
    output logic [NUM_CH-1:0] stop_p,
    output logic [NUM_CH-1:0] busy,
    output logic [NUM_CH-1:0] tmo_p,
    output logic [NUM_CH-1:0] arb_lost_p
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } bus_state_t;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic          scl_q;
        logic          sda_q;
        logic [TW-1:0] tcnt;
        bus_state_t    state_q;
        bus_state_t    state_d;
        logic          start_c;
        logic          stop_c;
        logic          tmo_c;
        logic          arb_c;

        i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
            .clk    (clk),
            .rst_n  (rst_n),
            .line_in(scl_in[i]),
            .line_f (scl_f[i])
        );

        i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
            .clk    (clk),
            .rst_n  (rst_n),
            .line_in(sda_in[i]),
            .line_f (sda_f[i])
        );

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                scl_q   <= 1'b1;
                sda_q   <= 1'b1;
                tcnt    <= '0;
                state_q <= IDLE;
            end else begin
                scl_q   <= scl_f[i];
                sda_q   <= sda_f[i];
                state_q <= state_d;
                if (state_q != BUSY || scl_f[i]) begin
                    tcnt <= '0;
                end else if (tcnt != TMO_MAX) begin
                    tcnt <= tcnt + TW'(1);
                end
            end
        end

        // Requiring SCL high on both sides of the SDA edge also rejects simultaneous SCL/SDA changes.
        always_comb begin
            start_c = sda_q & ~sda_f[i] & scl_q & scl_f[i];
            stop_c  = ~sda_q & sda_f[i] & scl_q & scl_f[i];
            tmo_c   = (state_q == BUSY) & ~scl_f[i] & (tcnt == TMO_LAST);
            arb_c   = (state_q == BUSY) & ~scl_q & scl_f[i] & ~sda_f[i] & sda_drive[i];
            state_d = state_q;
            case (state_q)
                IDLE: begin
                    if (start_c) begin
                        state_d = BUSY;
                    end
                end
                BUSY: begin
                    if (stop_c || tmo_c) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        assign start_p[i]    = start_c;
        assign rstart_p[i]   = start_c & (state_q == BUSY);
        assign stop_p[i]     = stop_c;
        assign busy[i]       = (state_q == BUSY);
        assign tmo_p[i]      = tmo_c;
        assign arb_lost_p[i] = arb_c;
    end

endmodule

// File: tb/tb_i2c_bus_cond_det.sv
// Bench for i2c_bus_cond_det: directed bus scenarios plus random line activity,
// every cycle compared against a behavioural model of filtering, conditions and bus state.

module tb_i2c_bus_cond_det;

    localparam int NCH = 2;
    localparam int FL  = 3;
    localparam int TMO = 20;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [NCH-1:0] scl_in;
    logic [NCH-1:0] sda_in;
    logic [NCH-1:0] sda_drive;
    logic [NCH-1:0] scl_f;
    logic [NCH-1:0] sda_f;
    logic [NCH-1:0] start_p;
    logic [NCH-1:0] rstart_p;
    logic [NCH-1:0] stop_p;
    logic [NCH-1:0] busy;
    logic [NCH-1:0] tmo_p;
    logic [NCH-1:0] arb_lost_p;

    int checks   = 0;
    int failures = 0;

    // observed pulse totals, written only by the monitor
    int obs_start[NCH];
    int obs_rstart[NCH];
    int obs_stop[NCH];
    int obs_tmo[NCH];
    int obs_arb[NCH];

    // behavioural model state
    bit [FL+1:0] m_hs[NCH];
    bit [FL+1:0] m_hd[NCH];
    bit          m_fs[NCH];
    bit          m_fd[NCH];
    bit          m_qs[NCH];
    bit          m_qd[NCH];
    bit          m_busy[NCH];
    int          m_run[NCH];
    bit          p_start[NCH];
    bit          p_stop[NCH];
    bit          p_tmo[NCH];

    i2c_bus_cond_det #(.NUM_CH(NCH), .FILT_LEN(FL), .TIMEOUT(TMO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .scl_in    (scl_in),
        .sda_in    (sda_in),
        .sda_drive (sda_drive),
        .scl_f     (scl_f),
        .sda_f     (sda_f),
        .start_p   (start_p),
        .rstart_p  (rstart_p),
        .stop_p    (stop_p),
        .busy      (busy),
        .tmo_p     (tmo_p),
        .arb_lost_p(arb_lost_p)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit filt_next(input bit [FL+1:0] h, input bit f);
        bit [FL-1:0] w;
        w = h[FL+1:2];
        if (w == '1) return 1'b1;
        if (w == '0) return 1'b0;
        return f;
    endfunction

    initial begin
        for (int c = 0; c < NCH; c++) begin
            m_hs[c] = '1; m_hd[c] = '1;
            m_fs[c] = 1'b1; m_fd[c] = 1'b1; m_qs[c] = 1'b1; m_qd[c] = 1'b1;
            m_busy[c] = 1'b0; m_run[c] = 0;
            p_start[c] = 1'b0; p_stop[c] = 1'b0; p_tmo[c] = 1'b0;
            obs_start[c] = 0; obs_rstart[c] = 0; obs_stop[c] = 0; obs_tmo[c] = 0; obs_arb[c] = 0;
        end
    end

    // ---------------- model + scoreboard ----------------
    always @(posedge clk) begin
        logic [NCH-1:0] e_sf, e_df, e_st, e_rs, e_sp, e_bz, e_tm, e_ar;
        for (int c = 0; c < NCH; c++) begin
            if (!rst_n) begin
                m_hs[c] = '1; m_hd[c] = '1;
                m_fs[c] = 1'b1; m_fd[c] = 1'b1; m_qs[c] = 1'b1; m_qd[c] = 1'b1;
                m_busy[c] = 1'b0;
            end else begin
                if (p_start[c]) m_busy[c] = 1'b1;
                else if (p_stop[c] || p_tmo[c]) m_busy[c] = 1'b0;
                m_hs[c] = {m_hs[c][FL:0], scl_in[c]};
                m_hd[c] = {m_hd[c][FL:0], sda_in[c]};
                m_qs[c] = m_fs[c];
                m_qd[c] = m_fd[c];
                m_fs[c] = filt_next(m_hs[c], m_fs[c]);
                m_fd[c] = filt_next(m_hd[c], m_fd[c]);
            end
        end
        #1;
        for (int c = 0; c < NCH; c++) begin
            bit st, sp;
            st = m_qd[c] && !m_fd[c] && m_qs[c] && m_fs[c];
            sp = !m_qd[c] && m_fd[c] && m_qs[c] && m_fs[c];
            m_run[c] = (rst_n && m_busy[c] && !m_fs[c]) ? m_run[c] + 1 : 0;
            p_start[c] = st;
            p_stop[c]  = sp;
            p_tmo[c]   = (m_run[c] == TMO);
            e_sf[c] = m_fs[c];
            e_df[c] = m_fd[c];
            e_st[c] = st;
            e_rs[c] = st && m_busy[c];
            e_sp[c] = sp;
            e_bz[c] = m_busy[c];
            e_tm[c] = p_tmo[c];
            e_ar[c] = m_busy[c] && !m_qs[c] && m_fs[c] && !m_fd[c] && sda_drive[c];
            obs_start[c]  += int'(start_p[c]);
            obs_rstart[c] += int'(rstart_p[c]);
            obs_stop[c]   += int'(stop_p[c]);
            obs_tmo[c]    += int'(tmo_p[c]);
            obs_arb[c]    += int'(arb_lost_p[c]);
        end
        check_eq("cyc_scl_f", 32'(scl_f), 32'(e_sf));
        check_eq("cyc_sda_f", 32'(sda_f), 32'(e_df));
        check_eq("cyc_start_p", 32'(start_p), 32'(e_st));
        check_eq("cyc_rstart_p", 32'(rstart_p), 32'(e_rs));
        check_eq("cyc_stop_p", 32'(stop_p), 32'(e_sp));
        check_eq("cyc_busy", 32'(busy), 32'(e_bz));
        check_eq("cyc_tmo_p", 32'(tmo_p), 32'(e_tm));
        check_eq("cyc_arb_lost_p", 32'(arb_lost_p), 32'(e_ar));
    end

    // ---------------- driver tasks ----------------
    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int b_st0, b_rs0, b_sp0, b_tm0, b_ar0, b_st1, b_sp1;
        int hold_scl[NCH];
        int hold_sda[NCH];

        rst_n     = 1'b0;
        scl_in    = 2'b10;
        sda_in    = 2'b10;
        sda_drive = 2'b11;

        // reset with ch0 lines low
        wait_clks(4);
        check_eq("rst_scl_f", 32'(scl_f), 32'h3);
        check_eq("rst_sda_f", 32'(sda_f), 32'h3);
        check_eq("rst_busy", 32'(busy), 32'h0);
        check_eq("rst_pulses", 32'({start_p, stop_p, tmo_p, arb_lost_p}), 32'h0);
        b_st0 = obs_start[0];
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #2;
        check_eq("rel_scl_f0_4clk", 32'(scl_f[0]), 32'h1);
        @(posedge clk);
        #2;
        check_eq("rel_scl_f0_5clk", 32'(scl_f[0]), 32'h0);
        check_eq("rel_sda_f0_5clk", 32'(sda_f[0]), 32'h0);
        wait_clks(6);
        check_eq("rel_no_start", 32'(obs_start[0] - b_st0), 32'h0);
        check_eq("rel_busy", 32'(busy), 32'h0);
        scl_in[0] = 1'b1;
        sda_in[0] = 1'b1;
        wait_clks(10);

        // glitch rejection on ch1
        b_st1 = obs_start[1];
        sda_in[1] = 1'b0;
        wait_clks(2);
        sda_in[1] = 1'b1;
        wait_clks(8);
        check_eq("glitch2_start", 32'(obs_start[1] - b_st1), 32'h0);
        check_eq("glitch2_sda_f1", 32'(sda_f[1]), 32'h1);
        sda_in[1] = 1'b0;
        wait_clks(8);
        check_eq("glitch3_start", 32'(obs_start[1] - b_st1), 32'h1);
        check_eq("glitch3_busy1", 32'(busy[1]), 32'h1);
        sda_in[1] = 1'b1;
        wait_clks(8);
        check_eq("glitch3_stop_busy1", 32'(busy[1]), 32'h0);

        // full transfer on ch0 with repeated START
        b_st0 = obs_start[0]; b_rs0 = obs_rstart[0]; b_sp0 = obs_stop[0]; b_tm0 = obs_tmo[0];
        b_st1 = obs_start[1]; b_sp1 = obs_stop[1];
        sda_in[0] = 1'b0;
        wait_clks(16);
        for (int b = 0; b < 9; b++) begin
            scl_in[0] = 1'b0;
            wait_clks(4);
            sda_in[0] = 1'($urandom_range(0, 1));
            wait_clks(12);
            scl_in[0] = 1'b1;
            wait_clks(16);
        end
        scl_in[0] = 1'b0; wait_clks(4); sda_in[0] = 1'b1; wait_clks(12);
        scl_in[0] = 1'b1; wait_clks(16); sda_in[0] = 1'b0; wait_clks(16);
        scl_in[0] = 1'b0; wait_clks(4); sda_in[0] = 1'b0; wait_clks(12);
        scl_in[0] = 1'b1; wait_clks(16); sda_in[0] = 1'b1; wait_clks(16);
        check_eq("xfer_starts", 32'(obs_start[0] - b_st0), 32'd2);
        check_eq("xfer_rstarts", 32'(obs_rstart[0] - b_rs0), 32'd1);
        check_eq("xfer_stops", 32'(obs_stop[0] - b_sp0), 32'd1);
        check_eq("xfer_no_tmo", 32'(obs_tmo[0] - b_tm0), 32'd0);
        check_eq("xfer_busy0", 32'(busy[0]), 32'h0);
        check_eq("xfer_ch1_quiet", 32'((obs_start[1] - b_st1) + (obs_stop[1] - b_sp1)), 32'd0);

        // clock stretch timeout on ch0
        b_tm0 = obs_tmo[0];
        sda_in[0] = 1'b0;
        wait_clks(8);
        scl_in[0] = 1'b0;
        wait_clks(TMO - 1);
        scl_in[0] = 1'b1;
        wait_clks(8);
        check_eq("stretch19_tmo", 32'(obs_tmo[0] - b_tm0), 32'd0);
        check_eq("stretch19_busy0", 32'(busy[0]), 32'h1);
        scl_in[0] = 1'b0;
        wait_clks(30);
        check_eq("stretch_tmo", 32'(obs_tmo[0] - b_tm0), 32'd1);
        check_eq("stretch_busy0", 32'(busy[0]), 32'h0);
        wait_clks(40);
        check_eq("stretch_tmo_once", 32'(obs_tmo[0] - b_tm0), 32'd1);
        sda_in[0] = 1'b1;
        wait_clks(4);
        scl_in[0] = 1'b1;
        wait_clks(8);

        // arbitration on ch0
        sda_in[0] = 1'b0;
        wait_clks(8);
        scl_in[0] = 1'b0;
        wait_clks(8);
        b_ar0 = obs_arb[0];
        sda_drive[0] = 1'b1;
        scl_in[0] = 1'b1;
        wait_clks(8);
        check_eq("arb_lost", 32'(obs_arb[0] - b_ar0), 32'd1);
        scl_in[0] = 1'b0;
        wait_clks(8);
        sda_drive[0] = 1'b0;
        scl_in[0] = 1'b1;
        wait_clks(8);
        check_eq("arb_driving_low", 32'(obs_arb[0] - b_ar0), 32'd1);
        sda_drive[0] = 1'b1;
        sda_in[0] = 1'b1;
        wait_clks(8);
        check_eq("arb_stop_busy0", 32'(busy[0]), 32'h0);

        // simultaneous SCL/SDA edges
        b_st0 = obs_start[0]; b_sp0 = obs_stop[0];
        scl_in[0] = 1'b0;
        sda_in[0] = 1'b0;
        wait_clks(10);
        check_eq("simul_no_start", 32'(obs_start[0] - b_st0), 32'd0);
        check_eq("simul_busy0", 32'(busy[0]), 32'h0);
        scl_in[0] = 1'b1;
        sda_in[0] = 1'b1;
        wait_clks(10);
        check_eq("simul_no_stop", 32'(obs_stop[0] - b_sp0), 32'd0);

        // random line activity, glitches, stretches and occasional reset
        for (int c = 0; c < NCH; c++) begin
            hold_scl[c] = $urandom_range(1, 28);
            hold_sda[c] = $urandom_range(1, 12);
        end
        for (int n = 0; n < 4000; n++) begin
            for (int c = 0; c < NCH; c++) begin
                if (hold_scl[c] == 0) begin
                    scl_in[c] = ~scl_in[c];
                    hold_scl[c] = $urandom_range(1, 28);
                end else begin
                    hold_scl[c]--;
                end
                if (hold_sda[c] == 0) begin
                    sda_in[c] = ~sda_in[c];
                    hold_sda[c] = $urandom_range(1, 12);
                end else begin
                    hold_sda[c]--;
                end
            end
            sda_drive = 2'($urandom_range(0, 3));
            rst_n = ($urandom_range(0, 999) != 0);
            wait_clks(1);
        end
        rst_n = 1'b1;
        scl_in = 2'b11;
        sda_in = 2'b11;
        wait_clks(12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
